// File: rtl/sar_seq_pkg.sv
// Shared types and defaults for the SAR ADC sequencer.
// Optional build macro used by the top level: SAR_SEQ_CONTINUOUS_EN.
package sar_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAMPLE  = 2'd1,
      CONVERT = 2'd2,
      DONE    = 2'd3
   } seqState_t;

   localparam int DEF_NBITS       = 8;
   localparam int DEF_SAMP_CYCLES = 4;
   localparam int SAMP_CNT_W      = 8;

endpackage

// File: rtl/sar_seq_reg.sv
// Successive-approximation register: holds the DAC trial code, the bit under
// test and a flag marking that a complete word has been resolved.
module sar_seq_reg
   import sar_seq_pkg::*;
#(
   parameter int NBITS = DEF_NBITS
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_comp,
   output logic [NBITS-1:0] o_dacCode,
   output logic [NBITS-1:0] o_nextCode,
   output logic             o_last,
   output logic             o_done
);

   localparam int IDXW = $clog2(NBITS);

   logic [NBITS-1:0] r_code;
   logic [IDXW-1:0]  r_idx;
   logic             r_done;
   logic [NBITS-1:0] w_nextCode;
   logic [IDXW-1:0]  w_idxDn;

   assign w_idxDn = r_idx - IDXW'(1);

   // Apply the comparator decision to the current bit, then arm the next trial bit.
   always_comb begin
      w_nextCode = r_code;
      if (!i_comp) begin
         w_nextCode[r_idx] = 1'b0;
      end
      if (r_idx != '0) begin
         w_nextCode[w_idxDn] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_code <= '0;
         r_idx  <= '0;
         r_done <= 1'b0;
      end else if (i_load) begin
         r_code <= {1'b1, {(NBITS-1){1'b0}}};
         r_idx  <= IDXW'(NBITS - 1);
         r_done <= 1'b0;
      end else if (i_step) begin
         r_code <= w_nextCode;
         if (r_idx == '0) begin
            r_done <= 1'b1;
         end else begin
            r_idx <= w_idxDn;
         end
      end
   end

   assign o_dacCode  = r_code;
   assign o_nextCode = w_nextCode;
   assign o_last     = (r_idx == '0);
   assign o_done     = r_done;

endmodule

// File: rtl/sar_seq.sv
// SAR ADC sequencer: sampling window, NBITS-step binary search, valid/ready result.
// Define SAR_SEQ_CONTINUOUS_EN to restart sampling straight after each accepted result.
module sar_seq
   import sar_seq_pkg::*;
#(
   parameter int NBITS       = DEF_NBITS,
   parameter int SAMP_CYCLES = DEF_SAMP_CYCLES
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_comp_out,
   output logic             o_samp_en,
   output logic             o_comp_clk,
   output logic [NBITS-1:0] o_dac_code,
   output logic             o_busy,
   output logic [NBITS-1:0] o_result,
   output logic             o_result_valid,
   input  logic             i_result_ready
);

   localparam logic [SAMP_CNT_W-1:0] SAMP_LAST = SAMP_CNT_W'(SAMP_CYCLES - 1);

   seqState_t             r_state;
   logic [SAMP_CNT_W-1:0] r_sampCnt;
   logic                  r_phase;
   logic                  r_sampEn;
   logic                  r_compClk;
   logic                  r_busy;
   logic                  r_resultValid;
   logic [NBITS-1:0]      r_result;

   logic                  w_load;
   logic                  w_step;
   logic                  w_last;
   logic                  w_done;
   logic [NBITS-1:0]      w_dacCode;
   logic [NBITS-1:0]      w_nextCode;

   assign w_load = (r_state == SAMPLE) && (r_sampCnt == SAMP_LAST);
   assign w_step = (r_state == CONVERT) && r_phase;

   sar_seq_reg #(.NBITS(NBITS)) u_reg (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_step     (w_step),
      .i_comp     (i_comp_out),
      .o_dacCode  (w_dacCode),
      .o_nextCode (w_nextCode),
      .o_last     (w_last),
      .o_done     (w_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_sampCnt     <= '0;
         r_phase       <= 1'b0;
         r_sampEn      <= 1'b0;
         r_compClk     <= 1'b0;
         r_busy        <= 1'b0;
         r_resultValid <= 1'b0;
         r_result      <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_sampCnt <= '0;
               if (i_start) begin
                  r_state  <= SAMPLE;
                  r_sampEn <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            SAMPLE: begin
               if (r_sampCnt == SAMP_LAST) begin
                  r_sampEn <= 1'b0;
                  r_phase  <= 1'b0;
                  r_state  <= CONVERT;
               end else begin
                  r_sampCnt <= r_sampCnt + SAMP_CNT_W'(1);
               end
            end
            // Settle cycle then strobe cycle; the decision lands at the end of the strobe.
            CONVERT: begin
               if (!r_phase) begin
                  r_phase   <= 1'b1;
                  r_compClk <= 1'b1;
               end else begin
                  r_phase   <= 1'b0;
                  r_compClk <= 1'b0;
                  if (w_last) begin
                     r_result      <= w_nextCode;
                     r_resultValid <= 1'b1;
                     r_state       <= DONE;
                  end
               end
            end
            DONE: begin
               if (i_result_ready && w_done) begin
                  r_resultValid <= 1'b0;
`ifdef SAR_SEQ_CONTINUOUS_EN
                  r_state   <= SAMPLE;
                  r_sampEn  <= 1'b1;
                  r_sampCnt <= '0;
`else
                  r_state   <= IDLE;
                  r_busy    <= 1'b0;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_samp_en      = r_sampEn;
   assign o_comp_clk     = r_compClk;
   assign o_dac_code     = w_dacCode;
   assign o_busy         = r_busy;
   assign o_result       = r_result;
   assign o_result_valid = r_resultValid;

endmodule

// File: tb/tb_sar_seq.sv
// Self-checking bench for sar_seq: ideal comparator against a random input level,
// expected trial codes and timing derived from the binary-search rules.
module tb_sar_seq;

   localparam int NB  = 8;
   localparam int S   = 4;
   localparam int LAT = S + 2 * NB + 1;
`ifdef SAR_SEQ_CONTINUOUS_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstN;
   logic          start;
   logic          compOut;
   logic          sampEn;
   logic          compClk;
   logic [NB-1:0] dacCode;
   logic          busy;
   logic [NB-1:0] result;
   logic          resultValid;
   logic          resultReady;
   logic [NB-1:0] vinLevel;

   int compared   = 0;
   int mismatched = 0;

   sar_seq #(.NBITS(NB), .SAMP_CYCLES(S)) dut (
      .i_clk          (clk),
      .i_rst_n        (rstN),
      .i_start        (start),
      .i_comp_out     (compOut),
      .o_samp_en      (sampEn),
      .o_comp_clk     (compClk),
      .o_dac_code     (dacCode),
      .o_busy         (busy),
      .o_result       (result),
      .o_result_valid (resultValid),
      .i_result_ready (resultReady)
   );

   always #5 clk = ~clk;

   // Ideal comparator: keep the trial bit when the input is at or above the DAC level.
   assign compOut = (vinLevel >= dacCode);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".samp_en"}, 32'(sampEn), 32'd0);
      checkOutput({tag, ".comp_clk"}, 32'(compClk), 32'd0);
      checkOutput({tag, ".dac_code"}, 32'(dacCode), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
      checkOutput({tag, ".result"}, 32'(result), 32'd0);
      checkOutput({tag, ".result_valid"}, 32'(resultValid), 32'd0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rstN  = 1'b0;
      start = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   // Trial code while bit b is under test: input bits above b, then b set, rest clear.
   function automatic logic [31:0] trialCode(input int vin, input int b);
      logic [31:0] above;
      above = ~((32'd1 << (b + 1)) - 32'd1);
      return (32'(vin) & above) | (32'd1 << b);
   endfunction

   // One full conversion from start; ends on the negedge after the result is offered
   // (or, with ready low, on the negedge of the first valid cycle).
   task automatic applyStimulus(input int vin, input bit readyHigh);
      int sampCnt = 0;
      int compCnt = 0;
      if (CONT) doReset();
      vinLevel    = NB'(vin);
      resultReady = readyHigh;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= LAT; n++) begin
         bit expSamp;
         bit expComp;
         expSamp = (n <= S);
         expComp = (n > S) && (n <= S + 2 * NB) && (((n - S) % 2) == 0);
         checkOutput($sformatf("samp_en@%0d", n), 32'(sampEn), 32'(expSamp));
         checkOutput($sformatf("comp_clk@%0d", n), 32'(compClk), 32'(expComp));
         checkOutput($sformatf("valid@%0d", n), 32'(resultValid), 32'(n == LAT));
         checkOutput($sformatf("busy@%0d", n), 32'(busy), 32'd1);
         if (expComp) begin
            checkOutput($sformatf("dac_code@%0d", n), 32'(dacCode),
                        trialCode(vin, NB - (n - S) / 2));
         end
         if (sampEn) sampCnt++;
         if (compClk) compCnt++;
         if (n < LAT) @(negedge clk);
      end
      checkOutput("result", 32'(result), 32'(vin));
      checkOutput("samp_en_cycles", 32'(sampCnt), 32'(S));
      checkOutput("comp_clk_pulses", 32'(compCnt), 32'(NB));
      if (readyHigh) begin
         @(negedge clk);
         checkOutput("valid_after_accept", 32'(resultValid), 32'd0);
         checkOutput("busy_after_accept", 32'(busy), 32'(CONT));
         checkOutput("samp_after_accept", 32'(sampEn), 32'(CONT));
      end
   endtask

   initial begin
      int rises[$];
      int vin;
      bit prevSamp;

      rstN        = 1'b0;
      start       = 1'b0;
      resultReady = 1'b0;
      vinLevel    = '0;
      #12;
      checkReset("reset");
      @(negedge clk);
      rstN = 1'b1;

      $display("[TB] directed levels 0xA5, 0x00, 0xFF");
      applyStimulus(32'hA5, 1'b1);
      applyStimulus(32'h00, 1'b1);
      applyStimulus(32'hFF, 1'b1);

      $display("[TB] random levels");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(int'($urandom_range(0, 255)), 1'b1);
      end

      $display("[TB] result held with ready low, start ignored");
      applyStimulus(32'hA5, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = ~start;
         checkOutput("hold.valid", 32'(resultValid), 32'd1);
         checkOutput("hold.result", 32'(result), 32'hA5);
         checkOutput("hold.samp_en", 32'(sampEn), 32'd0);
      end
      start       = 1'b0;
      resultReady = 1'b1;
      @(negedge clk);
      checkOutput("release.valid", 32'(resultValid), 32'd0);
      checkOutput("release.busy", 32'(busy), 32'(CONT));

      $display("[TB] async reset during third bit");
      if (CONT) doReset();
      vinLevel = NB'($urandom_range(0, 255));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (S + 4) @(negedge clk);
      checkOutput("mid.comp_clk", 32'(compClk), 32'd0);
      checkOutput("mid.busy", 32'(busy), 32'd1);
      #1 rstN = 1'b0;
      #1 checkReset("midreset");
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(int'($urandom_range(0, 255)), 1'b1);

      $display("[TB] back-to-back conversions");
      doReset();
      vin         = int'($urandom_range(0, 255));
      vinLevel    = NB'(vin);
      resultReady = 1'b1;
      start       = 1'b1;
      prevSamp    = 1'b0;
      for (int c = 0; c < 120 && rises.size() < 4; c++) begin
         @(negedge clk);
         if (CONT) start = 1'b0;
         if (sampEn && !prevSamp) rises.push_back(c);
         prevSamp = sampEn;
         checkOutput("exclusive", 32'(sampEn & compClk), 32'd0);
         if (resultValid) checkOutput("b2b.result", 32'(result), 32'(vin));
      end
      start = 1'b0;
      checkOutput("b2b.starts", 32'(rises.size()), 32'd4);
      for (int i = 1; i < rises.size(); i++) begin
         checkOutput("b2b.period", 32'(rises[i] - rises[i-1]), CONT ? 32'(LAT) : 32'(LAT + 1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
